// File: rtl/effect_avl_slave.sv
// Avalon-MM slave for the distortion effect: parameter registers plus
// show-ahead sample FIFOs to and from the effect core.
module effect_avl_slave #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid,
    output logic [DATA_W-1:0] distortion_gain,
    output logic [DATA_W-1:0] distortion_boost,
    output logic              bypass,
    output logic [DATA_W-1:0] smp_in_data,
    output logic              smp_in_valid,
    input  logic              smp_in_ready,
    input  logic [DATA_W-1:0] smp_out_data,
    input  logic              smp_out_valid,
    output logic              smp_out_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    logic wr_en, rd_en;
    logic a_gain, a_boost, a_stat, a_out, a_in;

    assign wr_en   = avs_write;
    assign rd_en   = avs_read && !avs_write;
    assign a_gain  = avs_address == 5'h01;
    assign a_boost = avs_address == 5'h02;
    assign a_stat  = avs_address == 5'h03;
    assign a_out   = avs_address == 5'h05;
    assign a_in    = avs_address == 5'h06;

    logic [DATA_W-1:0] in_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  in_wp, in_rp;
    logic [LVL_W-1:0]  in_lvl;
    logic in_full, in_empty, in_push, in_pop, in_ovf_set;

    logic [DATA_W-1:0] out_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  out_wp, out_rp;
    logic [LVL_W-1:0]  out_lvl;
    logic out_full, out_empty, out_push, out_pop, out_udf_set;

    logic in_ovf, out_udf;

    assign in_full      = in_lvl == FULL_LVL;
    assign in_empty     = in_lvl == '0;
    assign smp_in_valid = reset && !in_empty;
    assign smp_in_data  = in_mem[in_rp];
    assign in_pop       = smp_in_valid && smp_in_ready;
    // a full FIFO drops the write even if the core frees a slot this cycle
    assign in_push      = wr_en && a_in && !in_full;
    assign in_ovf_set   = wr_en && a_in && in_full;

    assign out_full      = out_lvl == FULL_LVL;
    assign out_empty     = out_lvl == '0;
    assign smp_out_ready = reset && !out_full;
    assign out_push      = smp_out_valid && smp_out_ready;
    assign out_pop       = rd_en && a_out && !out_empty;
    assign out_udf_set   = rd_en && a_out && out_empty;

    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wp] <= avs_writedata;
        if (out_push) out_mem[out_wp] <= smp_out_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_wp   <= '0;
            in_rp   <= '0;
            in_lvl  <= '0;
            out_wp  <= '0;
            out_rp  <= '0;
            out_lvl <= '0;
        end else begin
            if (in_push) in_wp <= in_wp + PTR_W'(1);
            if (in_pop) in_rp <= in_rp + PTR_W'(1);
            if (in_push && !in_pop) in_lvl <= in_lvl + LVL_W'(1);
            if (!in_push && in_pop) in_lvl <= in_lvl - LVL_W'(1);
            if (out_push) out_wp <= out_wp + PTR_W'(1);
            if (out_pop) out_rp <= out_rp + PTR_W'(1);
            if (out_push && !out_pop) out_lvl <= out_lvl + LVL_W'(1);
            if (!out_push && out_pop) out_lvl <= out_lvl - LVL_W'(1);
        end
    end

    logic stat_wr;
    assign stat_wr = wr_en && a_stat;

    always_ff @(posedge clk) begin
        if (!reset) begin
            distortion_gain  <= '0;
            distortion_boost <= '0;
            bypass           <= 1'b0;
            in_ovf           <= 1'b0;
            out_udf          <= 1'b0;
        end else begin
            if (wr_en && a_gain) distortion_gain <= avs_writedata;
            if (wr_en && a_boost) distortion_boost <= avs_writedata;
            if (stat_wr) bypass <= avs_writedata[0];
            in_ovf  <= in_ovf_set
                     | (in_ovf & !(stat_wr && avs_writedata[4]));
            out_udf <= out_udf_set
                     | (out_udf & !(stat_wr && avs_writedata[3]));
        end
    end

    logic [DATA_W-1:0] status, rd_mux;

    always_comb begin
        status                 = '0;
        status[0]              = bypass;
        status[1]              = in_full;
        status[2]              = in_empty;
        status[3]              = out_udf;
        status[4]              = in_ovf;
        status[8 +: LVL_W]     = in_lvl;
        status[16 +: LVL_W]    = out_lvl;
        rd_mux                 = '0;
        unique case (1'b1)
            a_gain:  rd_mux = distortion_gain;
            a_boost: rd_mux = distortion_boost;
            a_stat:  rd_mux = status;
            a_out:   rd_mux = out_empty ? '0 : out_mem[out_rp];
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= rd_en;
            if (rd_en) avs_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_effect_avl_slave.sv
// Directed bench for effect_avl_slave: register access, FIFO fill,
// drain, wrap, underflow/overflow flags and reset abort.
module tb_effect_avl_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [31:0] distortion_gain;
    logic [31:0] distortion_boost;
    logic        bypass;
    logic [31:0] smp_in_data;
    logic        smp_in_valid;
    logic        smp_in_ready;
    logic [31:0] smp_out_data;
    logic        smp_out_valid;
    logic        smp_out_ready;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    effect_avl_slave dut (
        .clk               (clk),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .distortion_gain   (distortion_gain),
        .distortion_boost  (distortion_boost),
        .bypass            (bypass),
        .smp_in_data       (smp_in_data),
        .smp_in_valid      (smp_in_valid),
        .smp_in_ready      (smp_in_ready),
        .smp_out_data      (smp_out_data),
        .smp_out_valid     (smp_out_valid),
        .smp_out_ready     (smp_out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        step();
        avs_write     = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [4:0] a,
                            input logic [31:0] exp);
        avs_address = a;
        avs_read    = 1'b1;
        step();
        avs_read    = 1'b0;
        chk({tag, "_rdv"}, 32'(avs_readdatavalid), 32'd1);
        chk(tag, avs_readdata, exp);
    endtask

    task automatic core_push(input logic [31:0] d);
        smp_out_data  = d;
        smp_out_valid = 1'b1;
        step();
        smp_out_valid = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        smp_in_ready  = 1'b0;
        smp_out_data  = '0;
        smp_out_valid = 1'b0;
        step();
        step();
        chk("rst_in_valid", 32'(smp_in_valid), 32'd0);
        chk("rst_out_ready", 32'(smp_out_ready), 32'd0);
        chk("rst_rdv", 32'(avs_readdatavalid), 32'd0);
        chk("rst_rdata", avs_readdata, 32'd0);
        reset = 1'b1;
        #1;
        bus_read("stat0", 5'h03, 32'h0000_0004);
        chk("idle_in_valid", 32'(smp_in_valid), 32'd0);
        chk("idle_out_ready", 32'(smp_out_ready), 32'd1);

        // parameter registers
        bus_write(5'h01, 32'h0000_0100);
        chk("gain_port", distortion_gain, 32'h0000_0100);
        bus_write(5'h02, 32'h0000_0003);
        chk("boost_port", distortion_boost, 32'h0000_0003);
        bus_read("gain_rd", 5'h01, 32'h0000_0100);
        bus_read("boost_rd", 5'h02, 32'h0000_0003);
        step();
        chk("rdv_drop", 32'(avs_readdatavalid), 32'd0);
        chk("rdata_hold", avs_readdata, 32'h0000_0003);
        bus_read("unmap_rd", 5'h07, 32'h0);
        bus_write(5'h07, 32'hDEAD_BEEF);
        bus_read("input_rd", 5'h06, 32'h0);

        // read and write together: write wins, no readdatavalid
        avs_address   = 5'h01;
        avs_writedata = 32'h0000_0055;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        step();
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        chk("rw_rdv", 32'(avs_readdatavalid), 32'd0);
        chk("rw_gain", distortion_gain, 32'h0000_0055);

        // fill input FIFO past full
        for (int i = 1; i <= 9; i++) bus_write(5'h06, 32'(i));
        chk("in_full_valid", 32'(smp_in_valid), 32'd1);
        bus_read("stat_full", 5'h03, 32'h0000_0812);
        smp_in_ready = 1'b1;
        #1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("in_v%0d", i), 32'(smp_in_valid), 32'd1);
            chk($sformatf("in_d%0d", i), smp_in_data, 32'(i));
            step();
        end
        chk("in_drained", 32'(smp_in_valid), 32'd0);
        smp_in_ready = 1'b0;
        bus_write(5'h03, 32'h0000_0010);
        bus_read("stat_ovf_clr", 5'h03, 32'h0000_0004);

        // output FIFO and underflow
        core_push(32'hA5A5_0001);
        core_push(32'hA5A5_0002);
        bus_read("out1", 5'h05, 32'hA5A5_0001);
        bus_read("out2", 5'h05, 32'hA5A5_0002);
        bus_read("out_udf", 5'h05, 32'h0);
        bus_read("stat_udf", 5'h03, 32'h0000_000C);
        bus_write(5'h03, 32'h0000_0008);
        chk("bypass_kept", 32'(bypass), 32'd0);
        bus_read("stat_udf_clr", 5'h03, 32'h0000_0004);
        bus_write(5'h03, 32'h0000_0001);
        chk("bypass_set", 32'(bypass), 32'd1);
        bus_read("stat_byp", 5'h03, 32'h0000_0005);
        bus_write(5'h03, 32'h0000_0000);

        // wrap, simultaneous push/pop, full
        for (int k = 0; k < 7; k++) core_push(32'h100 + 32'(k));
        smp_out_data  = 32'h107;
        smp_out_valid = 1'b1;
        bus_read("simul_rd", 5'h05, 32'h100);
        smp_out_valid = 1'b0;
        chk("simul_ready", 32'(smp_out_ready), 32'd1);
        bus_read("stat_lvl7", 5'h03, 32'h0007_0004);
        core_push(32'h108);
        chk("out_full_ready", 32'(smp_out_ready), 32'd0);
        core_push(32'h109);
        bus_read("stat_lvl8", 5'h03, 32'h0008_0004);
        for (int k = 1; k <= 8; k++)
            bus_read($sformatf("wrap%0d", k), 5'h05, 32'h100 + 32'(k));
        bus_read("stat_empty", 5'h03, 32'h0000_0004);

        // reset with data buffered and a read in flight
        bus_write(5'h03, 32'h0000_0001);
        for (int i = 0; i < 5; i++) bus_write(5'h06, 32'h20 + 32'(i));
        for (int k = 0; k < 5; k++) core_push(32'h30 + 32'(k));
        bus_read("stat_pre", 5'h03, 32'h0005_0501);
        avs_address = 5'h03;
        avs_read    = 1'b1;
        reset       = 1'b0;
        step();
        avs_read    = 1'b0;
        chk("abort_rdv", 32'(avs_readdatavalid), 32'd0);
        chk("abort_rdata", avs_readdata, 32'd0);
        chk("abort_in_valid", 32'(smp_in_valid), 32'd0);
        chk("abort_out_ready", 32'(smp_out_ready), 32'd0);
        chk("abort_gain", distortion_gain, 32'd0);
        chk("abort_boost", distortion_boost, 32'd0);
        chk("abort_bypass", 32'(bypass), 32'd0);
        reset = 1'b1;
        #1;
        chk("post_in_valid", 32'(smp_in_valid), 32'd0);
        bus_read("stat_post", 5'h03, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/effect_avl_slave.md
Name: effect_avl_slave

Overview:
Avalon-MM slave register file and sample buffer on the host side of the guitar effect path. The host writes effect parameters and input samples through it and reads processed samples and status back. A valid/ready sample stream connects it to the effect core (distortion). Each direction has its own synchronous show-ahead FIFO. The block sits between the host bus master and the effect core, all in the clk domain.

Parameters:
DATA_W, 32, sample and register width
FIFO_DEPTH, 8, entries per sample FIFO; power of two, >= 2
LVL_W, $clog2(FIFO_DEPTH)+1, FIFO level counter width (derived)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
avs_address  in  5  register address
avs_read  in  1  read strobe, one cycle per access
avs_write  in  1  write strobe, one cycle per access
avs_writedata  in  DATA_W  host write data
avs_readdata  out  DATA_W  read data, registered
avs_readdatavalid  out  1  read data qualifier
distortion_gain  out  DATA_W  GAIN register
distortion_boost  out  DATA_W  BOOST register
bypass  out  1  STATUS[0]
smp_in_data  out  DATA_W  input FIFO head, to core
smp_in_valid  out  1  input FIFO not empty
smp_in_ready  in  1  core accepts sample
smp_out_data  in  DATA_W  processed sample from core
smp_out_valid  in  1  core sample valid
smp_out_ready  out  1  output FIFO not full

Behaviour:
- Reset (reset==0 at a clk edge): both FIFOs emptied (pointers and levels = 0); GAIN = BOOST = 0; bypass = 0; sticky flags = 0; avs_readdata = 0; avs_readdatavalid = 0. While reset==0, smp_in_valid = 0 and smp_out_ready = 0. Reset asserted mid-transfer aborts the transfer; no pending readdatavalid survives reset.
- Register map:
  - 0x01 GAIN: RW.
  - 0x02 BOOST: RW.
  - 0x03 STATUS: [0] bypass (RW); [1] in_full (RO); [2] in_empty (RO); [3] out_underflow (sticky, W1C); [4] in_overflow (sticky, W1C); [8+:LVL_W] in_level (RO); [16+:LVL_W] out_level (RO); all other bits read 0.
  - 0x05 OUTPUT: RO; a read pops the output FIFO.
  - 0x06 INPUT: WO; a write pushes the input FIFO; reads return 0.
  - Unmapped addresses: reads return 0; writes are ignored.
- Read latency: exactly 1. avs_read at edge N gives avs_readdatavalid=1 and data for the cycle after edge N+1; otherwise readdatavalid=0 and readdata holds its last value. STATUS reads sample state before any same-edge update.
- avs_read and avs_write both high: the write is serviced; the read is ignored (no readdatavalid, no pop).
- INPUT write while in_full (level==FIFO_DEPTH): data is dropped and in_overflow is set. This holds even if the core pops in the same cycle.
- OUTPUT read while out_empty: returns 0, readdatavalid still pulses, out_underflow is set, and no pointer moves.
- W1C write to STATUS in the same cycle as a new overflow/underflow event: the set wins.
- Core side, input FIFO: smp_in_valid = !in_empty; smp_in_data = head entry (show-ahead, combinational from storage). A pop occurs when smp_in_valid && smp_in_ready.
- Core side, output FIFO: smp_out_ready = !out_full. A push occurs when smp_out_valid && smp_out_ready.
- Simultaneous push and pop on one FIFO: both occur and the level is unchanged. On an empty FIFO, a push is visible at the head the cycle after the write edge (no fall-through).
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The level counter saturates at neither end, because the guards above prevent over- and under-run.

Test Plan:
- Reset, then read STATUS -> readdatavalid one cycle later; data = 0x0000_0004 (in_empty=1, levels 0); smp_in_valid=0; smp_out_ready=1.
- Write GAIN=0x0000_0100 and BOOST=0x0000_0003, then read both -> 0x100 and 0x3 each with latency 1; distortion_gain/distortion_boost match on the edge after the write.
- Hold smp_in_ready=0 and write INPUT 9 times with values 1..9 -> in_level=8, in_full=1, in_overflow=1. Release ready -> core receives 1..8 in order, one per cycle, then smp_in_valid=0.
- Core pushes 0xA5A5_0001 and 0xA5A5_0002; host reads OUTPUT three times -> 0xA5A5_0001, 0xA5A5_0002, then 0 with out_underflow=1. Write STATUS=0x8 -> out_underflow clears; bypass unchanged.
- Fill output FIFO to 7 entries, then same-cycle core push and host OUTPUT read -> level stays 7, smp_out_ready stays 1, data order preserved across pointer wrap.
- Assert reset for one cycle with 5 entries in each FIFO and a read in flight -> no readdatavalid, all levels 0, GAIN/BOOST/bypass = 0.
